// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM address,
// and captures {instruction, PC, PC+4} into the IF/ID pipeline register.
// Handles stall, flush, branch/jump redirects and exception redirects, and
// counts valid fetches.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] EXC_PC   = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        ExcReq,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IMemAddress,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        MisalignErr,
  output logic [31:0] FetchCount
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        bubble;
  logic        advance;

  assign pc_plus4    = pc + 32'd4;
  assign IMemAddress = pc;

  // Any redirect or flush squashes the instruction fetched this cycle.
  assign bubble  = Flush | ExcReq | Redirect;
  assign advance = ~bubble & ~Stall;

  // Next-PC selection: exception, then redirect, then stall hold, then PC+4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (ExcReq) begin
      pc <= EXC_PC;
    end else if (Redirect) begin
      pc <= {RedirectTarget[31:2], 2'b00};
    end else if (!Stall) begin
      pc <= pc_plus4;
    end
  end

  // Sticky flag for a redirect target that was not word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MisalignErr <= 1'b0;
    end else if (Redirect && (RedirectTarget[1:0] != 2'b00)) begin
      MisalignErr <= 1'b1;
    end
  end

  // IF/ID register: bubble on squash, hold on stall, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IFID_Instruction <= '0;
      IFID_PC          <= '0;
      IFID_PCPlus4     <= '0;
      IFID_Valid       <= 1'b0;
    end else if (bubble) begin
      IFID_Instruction <= '0;
      IFID_PC          <= '0;
      IFID_PCPlus4     <= '0;
      IFID_Valid       <= 1'b0;
    end else if (!Stall) begin
      IFID_Instruction <= IMemInstruction;
      IFID_PC          <= pc;
      IFID_PCPlus4     <= pc_plus4;
      IFID_Valid       <= 1'b1;
    end
  end

  // Performance counter: one count per valid instruction latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FetchCount <= '0;
    end else if (advance) begin
      FetchCount <= FetchCount + 32'd1;
    end
  end

endmodule
